// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - ALU issue sequencer: op FIFO feeding a registered issue slot
// Optional repeat expansion is built when ALU_ISSUE_REPEAT_EN is defined.
module alu_issue_seq #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [2:0]  in_a,
    input  logic [2:0]  in_b,
    input  logic [2:0]  in_d,
    input  logic [15:0] in_imm,
    input  logic        in_use_imm,
    input  logic        in_wreg,
    input  logic        in_wflags,
    input  logic [3:0]  in_count,
    input  logic        wr_pc,
    output logic [3:0]  alu_f,
    output logic [2:0]  a_idx,
    output logic [2:0]  b_idx,
    output logic [2:0]  d_idx,
    output logic        wr_reg,
    output logic        wr_flags,
    output logic [15:0] t16,
    output logic        sel_inp,
    output logic        busy,
    output logic        flush,
    output logic [1:0]  q_level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
`ifdef ALU_ISSUE_REPEAT_EN
    localparam int EW = 36;
    typedef enum logic [1:0] { IDLE = 2'd0, ISSUE = 2'd1, REPEAT = 2'd2 } state_t;
`else
    localparam int EW = 32;
    typedef enum logic [1:0] { IDLE = 2'd0, ISSUE = 2'd1 } state_t;
`endif

    state_t        state, state_n;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] in_entry, head;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] level;
    logic          push, pop, flush_now;
    logic          load_head, load_rep, clear_slot;

`ifdef ALU_ISSUE_REPEAT_EN
    logic [3:0] rem, rem_n, slot_count;
    assign in_entry = {in_count, in_op, in_a, in_b, in_d, in_imm, in_use_imm, in_wreg, in_wflags};
`else
    logic unused_count;
    assign unused_count = ^in_count;
    assign in_entry = {in_op, in_a, in_b, in_d, in_imm, in_use_imm, in_wreg, in_wflags};
`endif

    assign head      = mem[rptr];
    assign in_ready  = (level < CW'(DEPTH)) & ~wr_pc;
    assign push      = in_valid & in_ready;
    assign flush_now = wr_pc & (state != IDLE);
    assign busy      = (level != '0) | (state != IDLE);
    assign q_level   = level[1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            level <= level + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        load_head  = 1'b0;
        load_rep   = 1'b0;
        clear_slot = 1'b0;
`ifdef ALU_ISSUE_REPEAT_EN
        rem_n      = rem;
`endif
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    load_head = 1'b1;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
`ifdef ALU_ISSUE_REPEAT_EN
                if (slot_count != 4'd0) begin
                    load_rep = 1'b1;
                    rem_n    = slot_count;
                    state_n  = REPEAT;
                end else
`endif
                if (level != '0) begin
                    pop       = 1'b1;
                    load_head = 1'b1;
                end else begin
                    clear_slot = 1'b1;
                    state_n    = IDLE;
                end
            end
`ifdef ALU_ISSUE_REPEAT_EN
            REPEAT: begin
                rem_n = rem - 4'd1;
                // Last repeat leaves through the same exit as a plain issue.
                if (rem == 4'd1) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        load_head = 1'b1;
                        state_n   = ISSUE;
                    end else begin
                        clear_slot = 1'b1;
                        state_n    = IDLE;
                    end
                end
            end
`endif
            default: begin
                clear_slot = 1'b1;
                state_n    = IDLE;
            end
        endcase
        if (flush_now) begin
            state_n    = IDLE;
            pop        = 1'b0;
            load_head  = 1'b0;
            load_rep   = 1'b0;
            clear_slot = 1'b1;
`ifdef ALU_ISSUE_REPEAT_EN
            rem_n      = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_slot) begin
            alu_f    <= '0;
            a_idx    <= '0;
            b_idx    <= '0;
            d_idx    <= '0;
            wr_reg   <= 1'b0;
            wr_flags <= 1'b0;
            t16      <= '0;
            sel_inp  <= 1'b0;
        end else if (load_head) begin
            alu_f    <= head[31:28];
            a_idx    <= head[27:25];
            b_idx    <= head[24:22];
            d_idx    <= head[21:19];
            t16      <= head[18:3];
            sel_inp  <= head[2];
            wr_reg   <= head[1];
            wr_flags <= head[0];
        end else if (load_rep) begin
            // Repeats chain the op on its own destination register.
            a_idx   <= d_idx;
            b_idx   <= d_idx;
            sel_inp <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flush <= 1'b0;
        else     flush <= flush_now;
    end

`ifdef ALU_ISSUE_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rem        <= 4'd0;
            slot_count <= 4'd0;
        end else begin
            rem <= rem_n;
            if (clear_slot)     slot_count <= 4'd0;
            else if (load_head) slot_count <= head[35:32];
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized bench for alu_issue_seq against a queue-based issue model
module tb_alu_issue_seq;
    localparam int DEPTH = 2;
`ifdef ALU_ISSUE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  d;
        logic [15:0] imm;
        logic        use_imm;
        logic        wreg;
        logic        wflags;
        logic [3:0]  count;
    } op_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_use_imm, in_wreg, in_wflags, wr_pc;
    logic [3:0]  in_op, in_count, alu_f;
    logic [2:0]  in_a, in_b, in_d, a_idx, b_idx, d_idx;
    logic [15:0] in_imm, t16;
    logic        wr_reg, wr_flags, sel_inp, busy, flush;
    logic [1:0]  q_level;

    always #5 clk = ~clk;

    alu_issue_seq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_wreg(in_wreg), .in_wflags(in_wflags),
        .in_count(in_count), .wr_pc(wr_pc), .alu_f(alu_f), .a_idx(a_idx),
        .b_idx(b_idx), .d_idx(d_idx), .wr_reg(wr_reg), .wr_flags(wr_flags),
        .t16(t16), .sel_inp(sel_inp), .busy(busy), .flush(flush), .q_level(q_level)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    op_t q[$];
    op_t slot;
    bit  slot_v  = 1'b0;
    bit  rep     = 1'b0;
    bit  flush_m = 1'b0;
    int  left    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic op_t mk(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] d, input logic [15:0] imm, input logic ui,
                               input logic wreg, input logic wflags, input logic [3:0] cnt);
        op_t o;
        o = '{op: f, a: a, b: b, d: d, imm: imm, use_imm: ui, wreg: wreg, wflags: wflags, count: cnt};
        return o;
    endfunction

    function automatic op_t rnd_op();
        logic [3:0] cnt;
        cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        return mk(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), cnt);
    endfunction

    // Expected datapath-facing view: an empty slot drives zeros; repeats read/write d.
    function automatic logic [35:0] exp_out();
        logic [3:0]  f;
        logic [2:0]  a, b, d;
        logic [15:0] imm;
        logic        wr, wf, sel, bsy;
        {f, a, b, d, imm, wr, wf, sel} = '0;
        if (slot_v) begin
            f   = slot.op;
            d   = slot.d;
            a   = rep ? slot.d : slot.a;
            b   = rep ? slot.d : slot.b;
            imm = slot.imm;
            sel = rep ? 1'b0 : slot.use_imm;
            wr  = slot.wreg;
            wf  = slot.wflags;
        end
        bsy = slot_v || (q.size() != 0);
        return {f, a, b, d, wr, wf, imm, sel, bsy, flush_m, 2'(q.size())};
    endfunction

    task automatic cycle(input logic r, input logic v, input op_t o, input logic pc, output bit acc);
        logic rdy_m;
        @(negedge clk);
        rst = r; in_valid = v; wr_pc = pc;
        in_op = o.op; in_a = o.a; in_b = o.b; in_d = o.d; in_imm = o.imm;
        in_use_imm = o.use_imm; in_wreg = o.wreg; in_wflags = o.wflags; in_count = o.count;
        #1;
        rdy_m = (q.size() < DEPTH) && !pc;
        check("in_ready", 64'(in_ready), 64'(rdy_m));
        acc = v && rdy_m && !r;
        if (r) begin
            q.delete(); slot_v = 0; rep = 0; left = 0; flush_m = 0;
        end else if (pc && slot_v) begin
            q.delete(); slot_v = 0; rep = 0; left = 0; flush_m = 1;
        end else begin
            flush_m = 0;
            if (slot_v && left > 0) begin
                left--;
                rep = 1;
            end else begin
                slot_v = 0;
                rep    = 0;
                if (q.size() > 0) begin
                    slot   = q.pop_front();
                    slot_v = 1;
                    left   = REP_EN ? int'(slot.count) : 0;
                end
            end
            if (acc) q.push_back(o);
        end
        @(posedge clk);
        #1;
        check("outputs", 64'({alu_f, a_idx, b_idx, d_idx, wr_reg, wr_flags, t16, sel_inp,
                              busy, flush, q_level}), 64'(exp_out()));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic offer(input op_t o);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 40) begin
            cycle(1'b0, 1'b1, o, 1'b0, acc);
            tries++;
        end
        if (!acc) check("offer_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        bit acc;
        rst = 1; in_valid = 0; wr_pc = 0; in_op = 0; in_a = 0; in_b = 0; in_d = 0;
        in_imm = 0; in_use_imm = 0; in_wreg = 0; in_wflags = 0; in_count = 0;
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0, acc);
        idle(1);

        offer(mk(4'h0, 3'd1, 3'd2, 3'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0));
        idle(3);

        offer(mk(4'hB, 3'd1, 3'd5, 3'd5, 16'h0001, 1'b1, 1'b1, 1'b1, 4'd3));
        offer(mk(4'h2, 3'd2, 3'd3, 3'd6, 16'h1234, 1'b0, 1'b1, 1'b0, 4'd0));
        offer(mk(4'h3, 3'd1, 3'd1, 3'd7, 16'h00FF, 1'b1, 1'b1, 1'b1, 4'd0));
        offer(mk(4'h4, 3'd0, 3'd2, 3'd1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'd0));
        idle(8);

        offer(mk(4'h5, 3'd2, 3'd4, 3'd3, 16'h0042, 1'b0, 1'b1, 1'b0, 4'd2));
        offer(mk(4'h6, 3'd1, 3'd1, 3'd1, 16'h0007, 1'b1, 1'b1, 1'b0, 4'd0));
        offer(mk(4'h7, 3'd6, 3'd5, 3'd2, 16'h8000, 1'b0, 1'b1, 1'b1, 4'd0));
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        idle(3);

        offer(mk(4'hB, 3'd5, 3'd5, 3'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd3));
        idle(2);
        cycle(1'b1, 1'b0, '0, 1'b0, acc);
        idle(6);

        offer(mk(4'h9, 3'd1, 3'd2, 3'd3, 16'h0101, 1'b0, 1'b1, 1'b0, 4'd7));
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        idle(1);
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        offer(mk(4'hA, 3'd7, 3'd6, 3'd5, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'd15));
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                  rnd_op(), 1'($urandom_range(0, 11) == 0), acc);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
